// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the host and the UART transmitter.
//   data        8  byte offered by the host, sampled only on handshake
//   data_valid  1  host has a byte on data
//   data_ready  1  transmitter accepts a byte this cycle
// Modports: master = host side, slave = transmitter side.
interface uart_tx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per valid/ready handshake onto tx as an 8N1
// frame (8E1/8O1 when built with UART_TX_PARITY_EN defined).
//
// Parameters:
//   CLK_FREQ    system clock, Hz
//   BAUD_RATE   line rate, bit/s; one bit lasts CLK_FREQ/BAUD_RATE clocks
//   STOP_BITS   1 or 2
//   PARITY_ODD  0 = even, 1 = odd (only meaningful with UART_TX_PARITY_EN)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   host      if   slave side of uart_tx_if (data, data_valid, data_ready)
//   tx        out  registered serial line, idles high
//   busy      out  frame in progress
//   tx_done   out  one-cycle pulse on the final cycle of the last stop bit
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line high, data_ready=1, waiting for a handshake
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first, bit_idx selects the bit
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | STOP_BITS stop bits (high), tx_done on last cycle
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_tx_if.slave   host,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_bit = (PARITY_ODD != 0) ? ~^byte_q : ^byte_q;
`endif

    assign bit_end         = (cnt_q == CNT_LAST);
    assign host.data_ready = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign tx              = tx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
        end
    end

    // tx_d always carries the level of the bit that starts at the next edge,
    // so the line is a flop output and only moves on bit boundaries.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        tx_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (host.data_valid) begin
                    byte_d  = host.data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = byte_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_bit;
`else
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = byte_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par_even;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if h0();
    uart_tx_if h1();
    logic tx0, busy0, done0, tx1, busy1, done1;

    // dut0: 1 stop bit, even parity; dut1: 2 stop bits, odd parity
    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .host(h0.slave),
        .tx(tx0), .busy(busy0), .tx_done(done0)
    );
    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .host(h1.slave),
        .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    int   n_checks = 0;
    int   n_err = 0;
    vec_t sb0[$];
    vec_t sb1[$];
    int   frames[2];
    int   n_sent[2];
    bit   mon_active[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction
    function automatic logic get_done(input int idx);
        return (idx == 0) ? done0 : done1;
    endfunction
    function automatic logic get_ready(input int idx);
        return (idx == 0) ? h0.data_ready : h1.data_ready;
    endfunction

    task automatic set_in(input int idx, input logic v, input logic [7:0] d);
        if (idx == 0) begin
            h0.data_valid = v;
            h0.data = d;
        end else begin
            h1.data_valid = v;
            h1.data = d;
        end
    endtask

    // Offer a byte, wait (bounded) for data_ready, push the expectation.
    // Returns on the negedge after the accepting posedge.
    task automatic send(input int idx, input logic [7:0] b, input logic pe, input bit hold);
        int   n;
        vec_t e;
        n = 0;
        set_in(idx, 1'b1, b);
        while (get_ready(idx) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("send_timeout", 32'd0, 32'd1);
            set_in(idx, 1'b0, b);
            return;
        end
        e.data = b;
        e.par_even = pe;
        if (idx == 0) sb0.push_back(e);
        else sb1.push_back(e);
        n_sent[idx]++;
        @(negedge clk);
        if (!hold) set_in(idx, 1'b0, b);
    endtask

    // Watches one line; on a start bit pops the expected byte and checks
    // every cycle of the frame against a model waveform.
    task automatic monitor(input int idx);
        vec_t       e;
        int         frame;
        int         bad;
        int         bi;
        logic       exp_bits [0:11];
        logic [7:0] got;
        bit         aborted;
        frame = (1 + 8 + PB + ((idx == 0) ? 1 : 2)) * CPB;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && get_tx(idx) === 1'b0) begin
                mon_active[idx] = 1'b1;
                e.data = 8'h00;
                e.par_even = 1'b0;
                if (idx == 0 && sb0.size() > 0) e = sb0.pop_front();
                else if (idx == 1 && sb1.size() > 0) e = sb1.pop_front();
                else check("unexpected_frame", 32'd1, 32'd0);
                for (int k = 0; k < 12; k++) exp_bits[k] = 1'b1;
                exp_bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) exp_bits[1+k] = e.data[k];
                if (PB == 1) exp_bits[9] = (idx == 0) ? e.par_even : ~e.par_even;
                bad = 0;
                got = 8'h00;
                aborted = 1'b0;
                for (int off = 0; off < frame; off++) begin
                    if (off > 0) @(negedge clk);
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = off / CPB;
                    if (get_tx(idx) !== exp_bits[bi]) bad++;
                    if (get_done(idx) !== (off == frame - 1)) bad++;
                    if (get_ready(idx) !== 1'b0) bad++;
                    if ((off % CPB) == CPB / 2 && bi >= 1 && bi <= 8) got[bi-1] = get_tx(idx);
                end
                if (!aborted) begin
                    check((idx == 0) ? "frame_wave0" : "frame_wave1", bad, 0);
                    check((idx == 0) ? "decode0" : "decode1", {24'd0, got}, {24'd0, e.data});
                    frames[idx]++;
                end
                mon_active[idx] = 1'b0;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        while (n < 3000 && (mon_active[idx] || get_ready(idx) !== 1'b1 ||
               ((idx == 0) ? sb0.size() : sb1.size()) != 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // After tx_done: exactly one idle-high cycle with data_ready, then start.
    task automatic gap_check();
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("gap_done_seen", {31'd0, done0}, 32'd1);
        @(negedge clk);
        check("gap_idle_tx", {31'd0, tx0}, 32'd1);
        check("gap_idle_ready", {31'd0, h0.data_ready}, 32'd1);
        @(negedge clk);
        check("gap_start_tx", {31'd0, tx0}, 32'd0);
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{8'h55, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b0};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h3C, 1'b0};
        tbl[6] = '{8'hA5, 1'b0};
        tbl[7] = '{8'h01, 1'b1};

        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready0", {31'd0, h0.data_ready}, 32'd1);
        check("rst_ready1", {31'd0, h1.data_ready}, 32'd1);

        // 0x55, one clock from handshake to start edge
        check("idle_high", {31'd0, tx0}, 32'd1);
        send(0, 8'h55, 1'b0, 1'b0);
        check("start_latency", {31'd0, tx0}, 32'd0);
        check("busy_in_frame", {31'd0, busy0}, 32'd1);
        wait_idle(0);

        for (int i = 0; i < 8; i++) begin
            fork
                send(0, tbl[i].data, tbl[i].par_even, 1'b0);
                send(1, tbl[i].data, tbl[i].par_even, 1'b0);
            join
        end
        wait_idle(0);
        wait_idle(1);

        // back-to-back with data_valid held
        send(0, 8'hA3, ^8'hA3, 1'b1);
        fork
            send(0, 8'h0F, ^8'h0F, 1'b0);
            gap_check();
        join
        wait_idle(0);

        // byte offered while busy is held off, running frame unchanged
        send(0, 8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        set_in(0, 1'b1, 8'hFF);
        repeat (5) @(negedge clk);
        check("busy_holdoff", {31'd0, h0.data_ready}, 32'd0);
        send(0, 8'hFF, 1'b0, 1'b0);
        wait_idle(0);

        // reset at clock 45 of a frame
        send(0, 8'h5A, ^8'h5A, 1'b0);
        repeat (44) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx0}, 32'd1);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_done", {31'd0, done0}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_done_hold", {31'd0, done0}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 8'h81, ^8'h81, 1'b0);
        wait_idle(0);

        // two stop bits
        send(1, 8'h3C, ^8'h3C, 1'b0);
        wait_idle(1);

        // every accepted byte except the aborted one produced a checked frame
        check("frame_count0", frames[0], n_sent[0] - 1);
        check("frame_count1", frames[1], n_sent[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
